// File: rtl/add_round_key_seq.sv
// -----------------------------------------------------------------------------
// add_round_key_seq
//
// Multi-cycle AES AddRoundKey engine. A full state block and its round key are
// captured in one handshake. The engine then XORs them LANE_BYTES bytes per
// clock into a result register. The finished block is presented behind a
// valid/ready handshake. Narrow lanes trade throughput for a smaller XOR array.
//
// Byte order: byte 0 is the most significant byte, [8*BLOCK_BYTES-1 -: 8].
// Lane k covers bytes k*LANE_BYTES .. k*LANE_BYTES+LANE_BYTES-1.
//
// Parameters:
//   LANE_BYTES   bytes XORed per clock. Legal values: 1, 2, 4, 8, 16.
//   BLOCK_BYTES  bytes per block. Must be a multiple of LANE_BYTES.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rstN      asynchronous active-low reset
//   i_clear     synchronous abort, active high; wins over both handshakes
//   i_inValid   state/key presented by the source
//   o_inReady   engine idle and able to accept a block
//   i_state     state block
//   i_key       round key, same byte order as i_state
//   o_outValid  result valid; held until i_outReady
//   i_outReady  downstream accepts the result
//   o_data      state XOR key; keeps the last result while idle
//   o_busy      high in RUN or DONE
//   o_parity    (ADD_ROUND_KEY_PARITY_EN only) even parity per result byte;
//               bit b belongs to byte b
//
// Optional feature macro: ADD_ROUND_KEY_PARITY_EN adds o_parity.
// -----------------------------------------------------------------------------
module add_round_key_seq #(
    parameter int LANE_BYTES  = 4,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rstN,
    input  logic                     i_clear,
    input  logic                     i_inValid,
    output logic                     o_inReady,
    input  logic [8*BLOCK_BYTES-1:0] i_state,
    input  logic [8*BLOCK_BYTES-1:0] i_key,
    output logic                     o_outValid,
    input  logic                     i_outReady,
    output logic [8*BLOCK_BYTES-1:0] o_data,
`ifdef ADD_ROUND_KEY_PARITY_EN
    output logic                     o_busy,
    output logic [BLOCK_BYTES-1:0]   o_parity
`else
    output logic                     o_busy
`endif
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int BLOCK_W = 8 * BLOCK_BYTES;
    localparam int LANE_W  = 8 * LANE_BYTES;
    localparam int N_LANES = BLOCK_BYTES / LANE_BYTES;
    // The lane counter keeps at least one bit, so a single-lane build still has
    // a well-formed counter that simply never leaves 0.
    localparam int CNT_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_LANES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (!(LANE_BYTES == 1 || LANE_BYTES == 2 || LANE_BYTES == 4 ||
              LANE_BYTES == 8 || LANE_BYTES == 16)) begin : g_bad_lane
            $error("add_round_key_seq: LANE_BYTES must be 1, 2, 4, 8 or 16");
        end
        if ((BLOCK_BYTES % LANE_BYTES) != 0) begin : g_bad_block
            $error("add_round_key_seq: BLOCK_BYTES must be a multiple of LANE_BYTES");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]         fsm_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLOCK_W-1:0] cap_state_q;
    logic [BLOCK_W-1:0] cap_key_q;
    logic [BLOCK_W-1:0] result_q;
    logic [BLOCK_W-1:0] lane_result;
`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [BLOCK_BYTES-1:0] parity_q;
    logic [BLOCK_BYTES-1:0] lane_parity;
`endif

    // -------------------------------------------------------------------------
    // Lane datapath: the result register with the lane selected by cnt_q
    // replaced by the XOR of the captured state and key for that lane.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        lane_result = result_q;
        for (int l = 0; l < N_LANES; l++) begin
            if (cnt_q == CNT_W'(l)) begin
                lane_result[BLOCK_W - (l + 1) * LANE_W +: LANE_W] =
                    cap_state_q[BLOCK_W - (l + 1) * LANE_W +: LANE_W] ^
                    cap_key_q[BLOCK_W - (l + 1) * LANE_W +: LANE_W];
            end
        end
    end

`ifdef ADD_ROUND_KEY_PARITY_EN
    // Parity of each byte in the current lane, taken from the freshly XORed
    // bytes so it is registered in the same edge as the data it describes.
    always_comb begin
        lane_parity = parity_q;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (cnt_q == CNT_W'(b / LANE_BYTES)) begin
                lane_parity[b] = ^lane_result[BLOCK_W - 8 * (b + 1) +: 8];
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Control and registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            // NOTE: the wide capture/result registers are reset on purpose so that
            // no earlier block is visible after reset.
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            cap_state_q <= '0;
            cap_key_q   <= '0;
            result_q    <= '0;
`ifdef ADD_ROUND_KEY_PARITY_EN
            parity_q    <= '0;
`endif
        end else if (i_clear) begin
            // Abort wins over both an input accept and an output handshake.
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            cap_state_q <= '0;
            cap_key_q   <= '0;
            result_q    <= '0;
`ifdef ADD_ROUND_KEY_PARITY_EN
            parity_q    <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values.
            case (fsm_q)
                S_IDLE: begin
                    if (i_inValid) begin
                        cap_state_q <= i_state;
                        cap_key_q   <= i_key;
                        result_q    <= '0;
`ifdef ADD_ROUND_KEY_PARITY_EN
                        parity_q    <= '0;
`endif
                        cnt_q       <= '0;
                        fsm_q       <= S_RUN;
                    end
                end

                S_RUN: begin
                    result_q <= lane_result;
`ifdef ADD_ROUND_KEY_PARITY_EN
                    parity_q <= lane_parity;
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        fsm_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_DONE: begin
                    // The result stays put until downstream takes it.
                    if (i_outReady) begin
                        fsm_q <= S_IDLE;
                    end
                end

                default: begin
                    fsm_q <= S_IDLE;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. They are decoded from the registered state, so they are glitch-free
    // with respect to the inputs and return to reset values without a clock.
    // -------------------------------------------------------------------------
    assign o_inReady  = (fsm_q == S_IDLE);
    assign o_outValid = (fsm_q == S_DONE);
    assign o_busy     = (fsm_q != S_IDLE);
    assign o_data     = result_q;
`ifdef ADD_ROUND_KEY_PARITY_EN
    assign o_parity   = parity_q;
`endif

endmodule

// File: tb/tb_add_round_key_seq.sv
// -----------------------------------------------------------------------------
// tb_add_round_key_seq
//
// Directed bench for add_round_key_seq. Five instances with LANE_BYTES = 1, 2,
// 4, 8 and 16 share one stimulus. Index 2 (LANE_BYTES=4) is the primary
// instance for the handshake, clear and reset scenarios. Expected values are
// the FIPS-197 Appendix B vectors and hand-computed constants.
// -----------------------------------------------------------------------------
module tb_add_round_key_seq;

    localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] SEQ_K  = 128'h0102030405060708090a0b0c0d0e0f10;
    // Parity of key bytes 0x01..0x10; bit b belongs to byte b.
    localparam logic [15:0]  SEQ_P  = 16'hb4cb;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state;
    logic [127:0] key;
    logic [4:0]   in_ready;
    logic [4:0]   out_valid;
    logic [4:0]   busy;
    logic [127:0] data [5];
`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [15:0]  parity [5];
`endif

    int tests_run;
    int tests_failed;

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            add_round_key_seq #(
                .LANE_BYTES (1 << g),
                .BLOCK_BYTES(16)
            ) u_dut (
                .i_clk     (clk),
                .i_rstN    (rst_n),
                .i_clear   (clear),
                .i_inValid (in_valid),
                .o_inReady (in_ready[g]),
                .i_state   (state),
                .i_key     (key),
                .o_outValid(out_valid[g]),
                .i_outReady(out_ready),
                .o_data    (data[g]),
                .o_busy    (busy[g])
`ifdef ADD_ROUND_KEY_PARITY_EN
                ,
                .o_parity  (parity[g])
`endif
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always end on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the instance idx raises o_outValid. lat is the number of edges
    // taken, or -1 if the budget runs out.
    task automatic wait_valid(input int idx, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (out_valid[idx]) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int exp_lat [5];
        int lat     [5];
        int wl;
        logic ir_bad;
        logic bp_bad;
        logic clr_bad;

        exp_lat      = '{16, 8, 4, 2, 1};
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        state        = '0;
        key          = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_in_ready",  128'(in_ready),  128'h1f);
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_busy",      128'(busy),      128'h0);
        check("rst_data",      data[2],         128'h0);
        rst_n = 1'b1;
        step();

        // ---------------- FIPS vector, all lane widths ----------------
        state    = FIPS_S;
        key      = FIPS_K;
        in_valid = 1'b1;
        step();                                  // accept edge
        in_valid = 1'b0;
        state    = ~FIPS_S;                      // post-accept changes must not matter
        key      = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        check("accept_in_ready", 128'(in_ready), 128'h0);
        check("accept_busy",     128'(busy),     128'h1f);
        for (int g = 0; g < 5; g++) lat[g] = -1;
        ir_bad = 1'b0;
        bp_bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            for (int g = 0; g < 5; g++) begin
                if (out_valid[g] && lat[g] < 0) lat[g] = k;
            end
            if (in_ready !== 5'h00) ir_bad = 1'b1;
            // LANE_BYTES=4 is done from edge 4 and must hold under backpressure.
            if (k >= 4 && (out_valid[2] !== 1'b1 || data[2] !== FIPS_R)) bp_bad = 1'b1;
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("latency_lane%0d", 1 << g), 128'(lat[g]), 128'(exp_lat[g]));
            check($sformatf("data_lane%0d", 1 << g), data[g], FIPS_R);
        end
        check("in_ready_low_run_done", 128'(ir_bad), 128'h0);
        check("backpressure_stable",   128'(bp_bad), 128'h0);

        // ---------------- release, then back-to-back block ----------------
        out_ready = 1'b1;
        step();
        check("release_in_ready",  128'(in_ready),  128'h1f);
        check("release_out_valid", 128'(out_valid), 128'h0);
        check("release_busy",      128'(busy),      128'h0);
        check("idle_data_kept",    data[2],         FIPS_R);
        state    = '1;
        key      = '0;
        in_valid = 1'b1;
        step();                                  // accept edge
        in_valid = 1'b0;
        step();
        step();
        step();
        check("b2b_not_yet_valid", 128'(out_valid[2]), 128'h0);
        step();
        check("b2b_valid", 128'(out_valid[2]), 128'h1);
        check("b2b_data",  data[2],            '1);
        repeat (20) step();                      // drain every instance to IDLE
        check("drain_idle", 128'(busy), 128'h0);

        // ---------------- clear during RUN ----------------
        out_ready = 1'b0;
        state     = FIPS_S;
        key       = FIPS_K;
        in_valid  = 1'b1;
        step();                                  // accept edge, RUN cycle 1
        step();                                  // RUN cycle 2
        check("clear_pre_busy", 128'(busy[2]), 128'h1);
        clear = 1'b1;                            // in_valid still high
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy",      128'(busy),      128'h0);
        check("clear_in_ready",  128'(in_ready),  128'h1f);
        check("clear_out_valid", 128'(out_valid), 128'h0);
        check("clear_data",      data[2],         128'h0);
        clr_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid !== 5'h00 || busy !== 5'h00) clr_bad = 1'b1;
        end
        check("clear_no_accept", 128'(clr_bad), 128'h0);

        // re-issued block completes normally
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(2, 10, wl);
        check("reissue_latency", 128'(wl), 128'd4);
        check("reissue_data",    data[2],  FIPS_R);

        // ---------------- async reset mid-DONE ----------------
        #2;
        rst_n = 1'b0;
        #1;                                      // no clock edge in between
        check("arst_out_valid", 128'(out_valid), 128'h0);
        check("arst_data",      data[2],         128'h0);
        check("arst_busy",      128'(busy),      128'h0);
        check("arst_in_ready",  128'(in_ready),  128'h1f);
        #10;
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 128'(in_ready), 128'h1f);
        check("post_rst_busy",     128'(busy),     128'h0);

        // ---------------- zero state, incrementing key ----------------
        state    = '0;
        key      = SEQ_K;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(0, 24, wl);                   // slowest instance
        check("seq_latency_lane1", 128'(wl), 128'd16);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("seq_data_lane%0d", 1 << g), data[g], SEQ_K);
`ifdef ADD_ROUND_KEY_PARITY_EN
            check($sformatf("parity_lane%0d", 1 << g), 128'(parity[g]), 128'(SEQ_P));
`endif
        end
        out_ready = 1'b1;
        step();
        check("seq_release", 128'(busy), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
